// File: rtl/z80_bus_ctrl_pkg.sv
// z80_bus_pkg: shared definitions for the z80 bus-cycle sequencer.
//   - T-state encodings (IDLE/T1/T2/TW/T3) as legacy-style constants
//   - wait-state counter width and limits
//   - bus strobe bundle type, its idle value and a per-state strobe decoder
package z80_bus_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_TW   = 3'd3;
    localparam logic [2:0] ST_T3   = 3'd4;

    localparam int unsigned        WCNT_W   = 32'd4;
    localparam int unsigned        WAIT_MAX = (32'd1 << WCNT_W) - 32'd1;
    localparam logic [WCNT_W-1:0]  WCNT_ONE = 4'd1;

    // Inactive level of every active-low strobe.
    localparam logic STROBE_IDLE = 1'b1;

    typedef struct packed {
        logic n_mreq;
        logic n_iorq;
        logic n_rd;
        logic n_wr;
        logic n_m1;
    } strobes_t;

    // Strobe levels for a given T-state; m1 must already be qualified
    // (forced to 0 for I/O or write cycles) by the caller.
    function automatic strobes_t strobe_decode(input logic [2:0] st,
                                               input logic       io,
                                               input logic       we,
                                               input logic       m1);
        strobes_t s;
        s = {5{STROBE_IDLE}};
        case (st)
            ST_T1: begin
                s.n_mreq = io;
                s.n_rd   = io | we;   // only memory reads strobe n_rd in T1
                s.n_m1   = ~m1;
            end
            ST_T2, ST_TW: begin
                s.n_mreq = io;
                s.n_iorq = ~io;
                s.n_rd   = we;
                s.n_wr   = ~we;
                s.n_m1   = ~m1;
            end
            ST_T3: begin
                s.n_mreq = io;
                s.n_iorq = ~io;
                s.n_rd   = we;
                s.n_wr   = ~we;
                s.n_m1   = STROBE_IDLE;
            end
            default: begin
                s = {5{STROBE_IDLE}};
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/z80_bus_ctrl_if.sv
// z80_bus_ctrl_if: request/response handshake plus pad-side bus signals.
//   slave  modport: the sequencer (accepts requests, drives the pads)
//   master modport: the requesting core / pad model
interface z80_bus_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_io;
    logic              req_m1;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              n_wait;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              dout_en;
    logic              n_mreq;
    logic              n_iorq;
    logic              n_rd;
    logic              n_wr;
    logic              n_m1;

    modport slave (
        input  req_valid, req_we, req_io, req_m1, req_addr, req_wdata, n_wait, din,
        output req_ready, rsp_valid, rsp_rdata, addr, dout, dout_en,
               n_mreq, n_iorq, n_rd, n_wr, n_m1
    );

    modport master (
        output req_valid, req_we, req_io, req_m1, req_addr, req_wdata, n_wait, din,
        input  req_ready, rsp_valid, rsp_rdata, addr, dout, dout_en,
               n_mreq, n_iorq, n_rd, n_wr, n_m1
    );
endinterface

// File: rtl/z80_bus_ctrl_sync.sv
// z80_sync: STAGES-deep flop synchroniser, flops reset to 1 (inactive for an
// active-low input). STAGES = 0 passes the input straight through.
//   clk, n_reset : clock, async active-low reset
//   d            : asynchronous input
//   q            : synchronised output
module z80_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);
    if (STAGES == 0) begin : g_bypass
        assign q = d;
    end else begin : g_sync
        logic [STAGES-1:0] sync_q;
        logic [STAGES-1:0] sync_d;

        // Shift the input one stage per clock.
        always_comb begin
            sync_d    = sync_q;
            sync_d[0] = d;
            for (int i = 1; i < STAGES; i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        // Synchroniser flops.
        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                sync_q <= '1;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign q = sync_q[STAGES-1];
    end
endmodule

// File: rtl/z80_bus_ctrl.sv
// z80_bus_ctrl: turns one-word core requests into Z80 T-state bus cycles.
//   clk, n_reset : clock, async active-low reset
//   bus (slave)  : req_* handshake in, rsp_* read response out, n_wait/din
//                  from pads, addr/dout/dout_en and active-low strobes out.
// All pad outputs are registered and are decoded from the next state, so
// they line up with the T-state the FSM is in during each cycle.
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 1,
    parameter int WAIT_SYNC = 2
) (
    input  logic          clk,
    input  logic          n_reset,
    z80_bus_ctrl_if.slave bus
);
    if ((MEM_WAIT < 0) || (MEM_WAIT > WAIT_MAX) || (IO_WAIT < 0) || (IO_WAIT > WAIT_MAX)) begin : g_bad_wait
        $error("z80_bus_ctrl: MEM_WAIT/IO_WAIT must be in 0..15");
    end

    logic [2:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              we_q, we_d, io_q, io_d, m1_q, m1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              dout_en_q, dout_en_d;
    strobes_t          strobes_q, strobes_d;
    logic              wait_s;
    logic              accept_s;

    z80_sync #(.STAGES(WAIT_SYNC)) u_wait_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (bus.n_wait),
        .q       (wait_s)
    );

    assign accept_s = bus.req_valid && ((state_q == ST_IDLE) || (state_q == ST_T3));

    // Request latching and T-state sequencing.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        io_d    = io_q;
        m1_d    = m1_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        if (accept_s) begin
            we_d   = bus.req_we;
            io_d   = bus.req_io;
            m1_d   = bus.req_m1 & ~bus.req_io & ~bus.req_we;
            addr_d = bus.req_addr;
            dout_d = bus.req_we ? bus.req_wdata : dout_q;
            wcnt_d = bus.req_io ? WCNT_W'(IO_WAIT) : WCNT_W'(MEM_WAIT);
        end else begin
            wcnt_d = wcnt_q;
        end
        case (state_q)
            ST_IDLE: state_d = accept_s ? ST_T1 : ST_IDLE;
            ST_T1:   state_d = ST_T2;
            ST_T2, ST_TW: begin
                // Programmed waits first; external n_wait only once they are spent.
                if (wcnt_q != '0) begin
                    state_d = ST_TW;
                    wcnt_d  = wcnt_q - WCNT_ONE;
                end else if (!wait_s) begin
                    state_d = ST_TW;
                end else begin
                    state_d = ST_T3;
                end
            end
            ST_T3:   state_d = accept_s ? ST_T1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered pad outputs and read response, decoded from the next state.
    always_comb begin
        rsp_valid_d = (state_q == ST_T3) && !we_q;
        rdata_d     = rsp_valid_d ? bus.din : rdata_q;
        req_ready_d = (state_d == ST_IDLE) || (state_d == ST_T3);
        strobes_d   = strobe_decode(state_d, io_d, we_d, m1_d);
        dout_en_d   = we_d && (state_d != ST_IDLE);
    end

    // State and output flops; reset aborts any cycle in progress.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            we_q        <= 1'b0;
            io_q        <= 1'b0;
            m1_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            dout_en_q   <= 1'b0;
            strobes_q   <= {5{STROBE_IDLE}};
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            we_q        <= we_d;
            io_q        <= io_d;
            m1_q        <= m1_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            dout_en_q   <= dout_en_d;
            strobes_q   <= strobes_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.addr      = addr_q;
    assign bus.dout      = dout_q;
    assign bus.dout_en   = dout_en_q;
    assign bus.n_mreq    = strobes_q.n_mreq;
    assign bus.n_iorq    = strobes_q.n_iorq;
    assign bus.n_rd      = strobes_q.n_rd;
    assign bus.n_wr      = strobes_q.n_wr;
    assign bus.n_m1      = strobes_q.n_m1;
endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Directed bench for z80_bus_ctrl (MEM_WAIT=0, IO_WAIT=1, WAIT_SYNC=2).
// Status vector = {req_ready, rsp_valid, dout_en, n_mreq, n_iorq, n_rd, n_wr, n_m1}.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_z80_bus_ctrl;
    logic clk;
    logic n_reset;
    int   n_checks;
    int   n_fail;

    z80_bus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    z80_bus_ctrl #(
        .ADDR_W(16), .DATA_W(8), .MEM_WAIT(0), .IO_WAIT(1), .WAIT_SYNC(2)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] status();
        return {bus.req_ready, bus.rsp_valid, bus.dout_en, bus.n_mreq,
                bus.n_iorq, bus.n_rd, bus.n_wr, bus.n_m1};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the sampling edge of the current cycle and check the status vector.
    task automatic step_chk(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, {24'd0, status()}, {24'd0, exp});
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_reset  = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_io    = 1'b0;
        bus.req_m1    = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 8'h00;
        bus.n_wait    = 1'b1;
        bus.din       = 8'h00;

        // Reset state
        #12;
        check("rst_status", {24'd0, status()}, 32'h0000_009F);
        check("rst_addr",   {16'd0, bus.addr}, 32'h0000_0000);
        check("rst_dout",   {24'd0, bus.dout}, 32'h0000_0000);
        check("rst_rdata",  {24'd0, bus.rsp_rdata}, 32'h0000_0000);
        n_reset = 1'b1;
        nxt();

        // Memory read 0x1234, zero waits
        bus.req_valid = 1'b1; bus.req_addr = 16'h1234;
        step_chk("mr_idle", 8'b100_11111);
        nxt(); bus.req_valid = 1'b0;
        step_chk("mr_t1", 8'b000_01011);
        check("mr_addr", {16'd0, bus.addr}, 32'h0000_1234);
        nxt(); step_chk("mr_t2", 8'b000_01011);
        nxt(); bus.din = 8'hA5;
        step_chk("mr_t3", 8'b100_01011);
        nxt(); step_chk("mr_rsp", 8'b110_11111);
        check("mr_rdata", {24'd0, bus.rsp_rdata}, 32'h0000_00A5);
        check("mr_addr_hold", {16'd0, bus.addr}, 32'h0000_1234);
        nxt(); step_chk("mr_after", 8'b100_11111);

        // Opcode fetch 0x0000
        bus.req_valid = 1'b1; bus.req_m1 = 1'b1; bus.req_addr = 16'h0000;
        nxt(); bus.req_valid = 1'b0; bus.req_m1 = 1'b0;
        step_chk("m1_t1", 8'b000_01010);
        check("m1_addr", {16'd0, bus.addr}, 32'h0000_0000);
        nxt(); step_chk("m1_t2", 8'b000_01010);
        nxt(); bus.din = 8'h3C;
        step_chk("m1_t3", 8'b100_01011);
        nxt(); step_chk("m1_rsp", 8'b110_11111);
        check("m1_rdata", {24'd0, bus.rsp_rdata}, 32'h0000_003C);

        // Memory write 0x55 to 0x8000
        nxt();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h8000; bus.req_wdata = 8'h55;
        nxt(); bus.req_valid = 1'b0; bus.req_we = 1'b0;
        step_chk("mw_t1", 8'b001_01111);
        check("mw_dout", {24'd0, bus.dout}, 32'h0000_0055);
        check("mw_addr", {16'd0, bus.addr}, 32'h0000_8000);
        nxt(); step_chk("mw_t2", 8'b001_01101);
        nxt(); step_chk("mw_t3", 8'b101_01101);
        nxt(); step_chk("mw_idle_norsp", 8'b100_11111);

        // I/O read 0x00FE, one automatic wait state
        bus.req_valid = 1'b1; bus.req_io = 1'b1; bus.req_addr = 16'h00FE;
        nxt(); bus.req_valid = 1'b0; bus.req_io = 1'b0;
        step_chk("ior_t1", 8'b000_11111);
        check("ior_addr", {16'd0, bus.addr}, 32'h0000_00FE);
        nxt(); step_chk("ior_t2", 8'b000_10011);
        nxt(); step_chk("ior_tw", 8'b000_10011);
        nxt(); bus.din = 8'h5A;
        step_chk("ior_t3", 8'b100_10011);
        nxt(); step_chk("ior_rsp", 8'b110_11111);
        check("ior_rdata", {24'd0, bus.rsp_rdata}, 32'h0000_005A);

        // Memory read 0x4000 with n_wait low for three cycles
        nxt();
        bus.req_valid = 1'b1; bus.req_addr = 16'h4000; bus.n_wait = 1'b0;
        nxt(); bus.req_valid = 1'b0;
        step_chk("wt_t1", 8'b000_01011);
        nxt(); step_chk("wt_t2", 8'b000_01011);
        nxt(); bus.n_wait = 1'b1;
        step_chk("wt_tw1", 8'b000_01011);
        nxt(); step_chk("wt_tw2", 8'b000_01011);
        nxt(); step_chk("wt_tw3", 8'b000_01011);
        nxt(); bus.din = 8'hC3;
        step_chk("wt_t3", 8'b100_01011);
        nxt(); step_chk("wt_rsp", 8'b110_11111);
        check("wt_rdata", {24'd0, bus.rsp_rdata}, 32'h0000_00C3);

        // Back-to-back: read 0x1111 then write 0x99 to 0x2222, req_valid held
        nxt();
        bus.req_valid = 1'b1; bus.req_addr = 16'h1111;
        nxt();
        bus.req_we = 1'b1; bus.req_addr = 16'h2222; bus.req_wdata = 8'h99;
        step_chk("bb_rd_t1", 8'b000_01011);
        nxt(); step_chk("bb_rd_t2", 8'b000_01011);
        nxt(); bus.din = 8'h77;
        step_chk("bb_rd_t3", 8'b100_01011);
        nxt(); bus.req_valid = 1'b0; bus.req_we = 1'b0;
        step_chk("bb_wr_t1", 8'b011_01111);
        check("bb_rdata", {24'd0, bus.rsp_rdata}, 32'h0000_0077);
        check("bb_addr", {16'd0, bus.addr}, 32'h0000_2222);
        check("bb_dout", {24'd0, bus.dout}, 32'h0000_0099);
        nxt(); step_chk("bb_wr_t2", 8'b001_01101);
        nxt(); step_chk("bb_wr_t3", 8'b101_01101);
        nxt(); step_chk("bb_idle_norsp", 8'b100_11111);

        // I/O write 0xAB to 0x0010, reset asserted during TW
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_io = 1'b1;
        bus.req_addr = 16'h0010; bus.req_wdata = 8'hAB;
        nxt(); bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_io = 1'b0;
        step_chk("iow_t1", 8'b001_11111);
        nxt(); step_chk("iow_t2", 8'b001_10101);
        nxt(); step_chk("iow_tw", 8'b001_10101);
        #1 n_reset = 1'b0;
        #1 check("rst_abort_now", {24'd0, status()}, 32'h0000_009F);
        nxt(); step_chk("rst_hold", 8'b100_11111);
        #1 n_reset = 1'b1;
        nxt();
        bus.req_valid = 1'b1; bus.req_addr = 16'h0ABC;
        step_chk("rst_idle_norsp", 8'b100_11111);
        nxt(); bus.req_valid = 1'b0;
        step_chk("post_t1", 8'b000_01011);
        check("post_addr", {16'd0, bus.addr}, 32'h0000_0ABC);
        nxt(); step_chk("post_t2", 8'b000_01011);
        nxt(); bus.din = 8'h11;
        step_chk("post_t3", 8'b100_01011);
        nxt(); step_chk("post_rsp", 8'b110_11111);
        check("post_rdata", {24'd0, bus.rsp_rdata}, 32'h0000_0011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
Parametrised bus-cycle sequencer between the z80 core's internal request interface and the pad ring.
- Converts one-word read/write requests (memory, I/O, opcode fetch) into Z80-style T-state sequences on n_mreq/n_iorq/n_rd/n_wr/n_m1, with address and data-bus drive enable.
- Generalises address/data width and adds programmable wait states, a synchronised external n_wait input and back-to-back issue.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
MEM_WAIT, 0, automatic wait states inserted in memory cycles (0..15)
IO_WAIT, 1, automatic wait states inserted in I/O cycles (0..15)
WAIT_SYNC, 2, synchroniser stages on n_wait (0 = used unsynchronised)

Ports:
clk  in  1  system clock, all state changes on rising edge
n_reset  in  1  asynchronous active-low reset
req_valid  in  1  core requests a bus cycle
req_ready  out  1  cycle accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_io  in  1  1 = I/O cycle, 0 = memory cycle
req_m1  in  1  opcode fetch (meaningful only for memory read)
req_addr  in  ADDR_W  cycle address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: read cycle completed
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
n_wait  in  1  external wait request, active low
din  in  DATA_W  data bus from pads
addr  out  ADDR_W  address to pads
dout  out  DATA_W  data to pads
dout_en  out  1  pad output enable for data bus
n_mreq, n_iorq, n_rd, n_wr, n_m1  out  1 each  active-low bus strobes

Behaviour:
- Reset (async assert, sync release): state IDLE; all strobes 1; dout_en 0; addr 0; dout 0; rsp_valid 0; rsp_rdata 0; req_ready 1; synchroniser flops 1.
  - Reset mid-cycle aborts the cycle immediately with no rsp_valid.
- States: IDLE, T1, T2, TW, T3. All outputs are registered and reflect the current state during the cycle.
- Accept: in IDLE or T3 with req_valid = 1:
  - latch addr/we/io/m1/wdata;
  - next state T1;
  - load wait counter with IO_WAIT if io, else MEM_WAIT.
- req_ready = 1 in IDLE and T3, 0 in T1/T2/TW.
- T1: addr driven.
  - Memory cycle: n_mreq = 0.
  - Memory read: n_rd = 0.
  - m1 && !io && !we: n_m1 = 0.
  - Write: dout = wdata, dout_en = 1.
- T2: strobes from T1 held.
  - I/O: n_iorq = 0, plus n_rd = 0 (read) or n_wr = 0 (write).
  - Memory write: n_wr = 0.
- Leaving T2 or TW:
  - if counter != 0 → TW, decrement counter;
  - else if synchronised n_wait == 0 → TW (counter stays 0);
  - else → T3.
  - n_wait is ignored in T1 and T3.
- TW: strobes and dout_en held as in T2.
- T3: strobes held.
  - Exit edge: read cycles capture din into rsp_rdata; rsp_valid = 1 in the following cycle for exactly one cycle.
  - Writes produce no rsp_valid.
  - n_m1 released (1) in T3.
- After T3:
  - no new request → IDLE, all strobes 1, dout_en 0, addr held;
  - new request accepted in T3 → T1 of the next cycle. Strobes still return to 1 for T1 decode (a fresh T1 re-asserts per new type).
- Latency, zero waits: accept in cycle 0 → T1 cycle 1, T2 cycle 2, T3 cycle 3, rsp_valid cycle 4. Each wait state adds 1 cycle.
- m1 with io = 1 or we = 1 is treated as m1 = 0.
- Wait counter width 4 bits; parameters > 15 are illegal (elaboration check).
- dout_en is never 1 during a read cycle or in IDLE.

Decomposition:
- Package z80_bus_pkg:
  - state encoding (IDLE/T1/T2/TW/T3);
  - wait counter width constant;
  - strobe idle value constant.
- Sub-module z80_sync: WAIT_SYNC-stage synchroniser with async reset to 1, instantiated for n_wait.

Test Plan:
- Memory read, MEM_WAIT=0, addr 0x1234, din 0xA5 in T3 → n_mreq/n_rd low cycles 1-3; rsp_valid cycle 4 with rsp_rdata 0xA5; n_iorq/n_wr stay 1.
- Opcode fetch m1=1, addr 0x0000 → n_m1 low cycles 1-2 only; memory write 0x55 to 0x8000 → dout_en 1 cycles 1-3, n_wr low cycles 2-3, no rsp_valid.
- I/O read, IO_WAIT=1, addr 0x00FE → one TW; n_iorq/n_rd low cycles 2-4; rsp_valid cycle 5.
- n_wait held low 3 cycles during T2, WAIT_SYNC=2 → TW count extends by 3 after sync delay; T3 only after sync'd n_wait returns 1; data captured correctly.
- Back-to-back: req_valid held with read then write queued → second T1 immediately after first T3, no IDLE gap; rsp_valid for read only.
- n_reset asserted during TW of an I/O write → all strobes 1, dout_en 0 the same instant; no rsp_valid; next request after release runs normally.
